// File: rtl/seven_seg_scanner_if.sv
// rtl/seven_seg_scanner_if.sv - digit value bus in, common-anode display pins out
interface seven_seg_scanner_if;
    logic       digit0_en_i;
    logic [3:0] digit0_i;
    logic       digit1_en_i;
    logic [3:0] digit1_i;
    logic       digit2_en_i;
    logic [3:0] digit2_i;
    logic       digit3_en_i;
    logic [3:0] digit3_i;
    logic [3:0] brightness_i;
    logic [3:0] anodes_o;
    logic [6:0] segments_o;
    logic       frame_o;

    modport master (
        output digit0_en_i, digit0_i, digit1_en_i, digit1_i,
        output digit2_en_i, digit2_i, digit3_en_i, digit3_i,
        output brightness_i,
        input  anodes_o, segments_o, frame_o
    );

    modport slave (
        input  digit0_en_i, digit0_i, digit1_en_i, digit1_i,
        input  digit2_en_i, digit2_i, digit3_en_i, digit3_i,
        input  brightness_i,
        output anodes_o, segments_o, frame_o
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - four-digit multiplexed seven-segment scanner with blanking and PWM
module seven_seg_scanner #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    seven_seg_scanner_if.slave  bus
);
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int CW = (DW > BW) ? DW : BW;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {ST_BLANK, ST_ON} state_t;

    // State registers describe the cycle that starts at the next clock edge,
    // so the pins registered at that edge line up exactly with that cycle.
    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      pwm_q, pwm_d;
    logic [3:0][3:0] snap_val_q, snap_val_d;
    logic [3:0]      snap_en_q, snap_en_d;
    logic [3:0]      anodes_q, anodes_d;
    logic [6:0]      segments_q, segments_d;
    logic            frame_q, frame_d;
    logic            lit;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    assign lit = (bus.brightness_i == 4'd15) || (pwm_q < bus.brightness_i);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        pwm_d      = pwm_q;
        snap_val_d = snap_val_q;
        snap_en_d  = snap_en_q;
        anodes_d   = 4'hF;
        segments_d = 7'h7F;
        frame_d    = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (idx_q == 2'd0 && cnt_q == '0) begin
                    snap_val_d = {bus.digit3_i, bus.digit2_i, bus.digit1_i, bus.digit0_i};
                    snap_en_d  = {bus.digit3_en_i, bus.digit2_en_i, bus.digit1_en_i, bus.digit0_en_i};
                    frame_d    = 1'b1;
                end
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                    pwm_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                segments_d = decode(snap_val_q[idx_q]);
                if (snap_en_q[idx_q] && lit) begin
                    anodes_d[idx_q] = 1'b0;
                end
                pwm_d = pwm_q + 4'd1;
                if (cnt_q == DWELL_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_BLANK;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            pwm_q      <= 4'd0;
            snap_val_q <= '0;
            snap_en_q  <= 4'd0;
            anodes_q   <= 4'hF;
            segments_q <= 7'h7F;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
            snap_val_q <= snap_val_d;
            snap_en_q  <= snap_en_d;
            anodes_q   <= anodes_d;
            segments_q <= segments_d;
            frame_q    <= frame_d;
        end
    end

    assign bus.anodes_o   = anodes_q;
    assign bus.segments_o = segments_q;
    assign bus.frame_o    = frame_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - scoreboard bench for seven_seg_scanner, two dwell settings
module tb_seven_seg_scanner;
    localparam int BLANK = 2;
    localparam int DW_A  = 8;
    localparam int DW_B  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scanner_if bus_a ();
    seven_seg_scanner_if bus_b ();

    seven_seg_scanner #(.DWELL_CYCLES(DW_A), .BLANK_CYCLES(BLANK)) u_dut_a (
        .clk_i (clk), .rst_ni (rst_n), .bus (bus_a)
    );
    seven_seg_scanner #(.DWELL_CYCLES(DW_B), .BLANK_CYCLES(BLANK)) u_dut_b (
        .clk_i (clk), .rst_ni (rst_n), .bus (bus_b)
    );

    typedef struct {
        int         dut;
        int         t;
        logic [3:0] an;
        logic [6:0] seg;
        logic       fr;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int t_a = 0;
    int t_b = 0;

    logic [3:0]  val_in [4];
    logic [3:0]  en_in;
    logic [3:0]  br;
    logic [15:0] snap_a_v, snap_b_v;
    logic [3:0]  snap_a_e, snap_b_e;
    logic [6:0]  dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic drive();
        bus_a.digit0_i = val_in[0]; bus_a.digit0_en_i = en_in[0];
        bus_a.digit1_i = val_in[1]; bus_a.digit1_en_i = en_in[1];
        bus_a.digit2_i = val_in[2]; bus_a.digit2_en_i = en_in[2];
        bus_a.digit3_i = val_in[3]; bus_a.digit3_en_i = en_in[3];
        bus_a.brightness_i = br;
        bus_b.digit0_i = val_in[0]; bus_b.digit0_en_i = en_in[0];
        bus_b.digit1_i = val_in[1]; bus_b.digit1_en_i = en_in[1];
        bus_b.digit2_i = val_in[2]; bus_b.digit2_en_i = en_in[2];
        bus_b.digit3_i = val_in[3]; bus_b.digit3_en_i = en_in[3];
        bus_b.brightness_i = br;
    endtask

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent model: position within the frame decides everything.
    function automatic exp_t model(input int dut, input int dwell, input int t,
                                   input logic [15:0] sv, input logic [3:0] se,
                                   input logic [3:0] b);
        exp_t e;
        int slot_len, pos, slot, w, p;
        slot_len = BLANK + dwell;
        pos  = t % (4 * slot_len);
        slot = pos / slot_len;
        w    = pos % slot_len;
        e.dut = dut;
        e.t   = t;
        e.fr  = (pos == 0);
        e.an  = 4'hF;
        e.seg = 7'h7F;
        if (w >= BLANK) begin
            p = (w - BLANK) % 16;
            e.seg = dec_tbl[sv[slot*4 +: 4]];
            if (se[slot] && ((b == 4'd15) || (p < int'(b)))) e.an[slot] = 1'b0;
        end
        return e;
    endfunction

    task automatic step();
        exp_t e;
        if (t_a % (4 * (BLANK + DW_A)) == 0) begin
            snap_a_v = {val_in[3], val_in[2], val_in[1], val_in[0]};
            snap_a_e = en_in;
        end
        if (t_b % (4 * (BLANK + DW_B)) == 0) begin
            snap_b_v = {val_in[3], val_in[2], val_in[1], val_in[0]};
            snap_b_e = en_in;
        end
        sb.push_back(model(0, DW_A, t_a, snap_a_v, snap_a_e, br));
        sb.push_back(model(1, DW_B, t_b, snap_b_v, snap_b_e, br));
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                check($sformatf("a t=%0d anodes", e.t), {3'b0, bus_a.anodes_o}, {3'b0, e.an});
                check($sformatf("a t=%0d segments", e.t), bus_a.segments_o, e.seg);
                check($sformatf("a t=%0d frame", e.t), {6'b0, bus_a.frame_o}, {6'b0, e.fr});
            end else begin
                check($sformatf("b t=%0d anodes", e.t), {3'b0, bus_b.anodes_o}, {3'b0, e.an});
                check($sformatf("b t=%0d segments", e.t), bus_b.segments_o, e.seg);
                check($sformatf("b t=%0d frame", e.t), {6'b0, bus_b.frame_o}, {6'b0, e.fr});
            end
        end
        t_a++;
        t_b++;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " a anodes"}, {3'b0, bus_a.anodes_o}, 7'h0F);
        check({tag, " a segments"}, bus_a.segments_o, 7'h7F);
        check({tag, " a frame"}, {6'b0, bus_a.frame_o}, 7'h00);
        check({tag, " b anodes"}, {3'b0, bus_b.anodes_o}, 7'h0F);
        check({tag, " b segments"}, bus_b.segments_o, 7'h7F);
        check({tag, " b frame"}, {6'b0, bus_b.frame_o}, 7'h00);
    endtask

    initial begin
        val_in[0] = 4'd1; val_in[1] = 4'd2; val_in[2] = 4'd3; val_in[3] = 4'd4;
        en_in = 4'hF;
        br    = 4'd15;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");

        @(negedge clk);
        rst_n = 1'b1;
        t_a = 0;
        t_b = 0;
        repeat (40) step();

        // Change digit2 while digit1 is lit; takes effect only at the next snapshot.
        while (t_a != 55) step();
        val_in[2] = 4'hA;
        drive();
        while (t_a != 120) step();

        en_in[1] = 1'b0;
        drive();
        repeat (80) step();
        en_in[1] = 1'b1;

        br = 4'd4;
        drive();
        repeat (144) step();
        br = 4'd0;
        drive();
        repeat (80) step();
        br = 4'd15;
        drive();

        while (t_a % 40 != 0) step();
        for (int v = 0; v < 16; v++) begin
            val_in[0] = 4'(v);
            drive();
            repeat (40) step();
        end

        // Reset asynchronously in the middle of digit2's lit slot.
        val_in[2] = 4'd3;
        drive();
        while (t_a % 40 != 26) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset held");
        @(negedge clk);
        rst_n = 1'b1;
        t_a = 0;
        t_b = 0;
        repeat (80) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Consumer end of the game's four-digit display interface: digitN_en/digitN value pairs in, multiplexed common-anode seven-segment pins out.
- Snapshots all four digits once per frame, so a frame never mixes old and new values.
- Scans the digits in time slots, with a blanking gap between slots to stop ghosting and a 4-bit PWM brightness control.
- Sits between the game top level and the board display pins.

Parameters:
DWELL_CYCLES, 1000, clock cycles each digit is in its ON slot (>=1)
BLANK_CYCLES, 16, clock cycles all anodes are off before each ON slot (>=1)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  reset, asynchronous, active-low
digit0_en_i  input  1  digit 0 visible
digit0_i  input  4  digit 0 hex value
digit1_en_i  input  1  digit 1 visible
digit1_i  input  4  digit 1 hex value
digit2_en_i  input  1  digit 2 visible
digit2_i  input  4  digit 2 hex value
digit3_en_i  input  1  digit 3 visible
digit3_i  input  4  digit 3 hex value
brightness_i  input  4  duty level; 0 = dark, 15 = full on
anodes_o  output  4  active-low digit select; bit N = digitN
segments_o  output  7  active-low segments, bit order {g,f,e,d,c,b,a}
frame_o  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (async assert on rst_ni low) sets:
  - anodes_o = 4'b1111, segments_o = 7'h7F, frame_o = 0;
  - state = BLANK, idx = 0, cycle counter = 0, pwm counter = 0;
  - snapshot values = 0, snapshot enables = 0.
- Reset is released synchronously in effect: the first rising edge with rst_ni high counts as cycle 1 of BLANK for idx 0.
- FSM states:
  - BLANK: all anodes high, segments 7'h7F. Stays BLANK_CYCLES cycles, then goes to ON.
  - ON: stays DWELL_CYCLES cycles, then goes to BLANK with idx = idx+1 mod 4.
- Frame = 4*(BLANK_CYCLES+DWELL_CYCLES) cycles; scan order is digit0, digit1, digit2, digit3, then wraps.
- Snapshot:
  - Taken on the first cycle of BLANK with idx = 0, including the first cycle after reset.
  - All eight digit inputs are registered together; frame_o = 1 in that same cycle.
  - Input changes at any other time have no effect until the next frame.
- In ON with idx = N:
  - segments_o = decode(snapshot value N), which holds through the whole slot.
  - anodes_o[N] = 0 when snapshot enable N = 1 AND lit; all other anodes = 1.
  - lit = (brightness_i == 15) OR (pwm counter < brightness_i).
  - The pwm counter is 4 bits, clears to 0 on entry to ON, increments every ON cycle and wraps 15 -> 0.
  - brightness_i is sampled live, not snapshotted.
- Disabled digit (snapshot enable = 0): its anode stays 1 for the whole slot; segments still show the decoded value. The slot is never skipped, so scan timing stays fixed.
- Outputs are registers: the pin values for a cycle are registered from that cycle's next-state, so anode low aligns exactly with the ON cycles. There are no combinational paths from inputs to outputs.
- Adjacent ON slots are separated by at least BLANK_CYCLES cycles with all anodes high, so two anodes are never low in the same cycle.
- Decode table (active-low, hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Counter widths: $clog2 of the parameter values, minimum 1 bit. The counter compares against the parameter minus 1, then resets.
- Reset mid-slot: outputs return to reset values immediately, and the scan restarts at idx 0 with a fresh snapshot.

Test Plan:
- DWELL=8, BLANK=2; all digits enabled, values 1,2,3,4; brightness 15 -> frame_o pulses every 40 cycles. anodes_o sequence per frame is 1111 x2, 1110 x8, 1111 x2, 1101 x8, 1111 x2, 1011 x8, 1111 x2, 0111 x8. segments_o = 79, 24, 30, 19 during the matching ON slots.
- Change digit2_i from 3 to A mid-frame, during digit1's ON slot -> digit2 still shows 30 this frame and shows 08 from the next frame on.
- digit1_en_i = 0 -> anodes_o[1] stays 1 through its slot, and other slots keep their exact timing.
- brightness 4, DWELL=16 -> in each ON slot the active anode is low for pwm counts 0-3, i.e. 4 of the 16 cycles. Brightness 0 -> anodes stay 1111 permanently.
- Sweep all 16 values on digit0 -> segments_o matches the decode table entry for each value.
- Assert rst_ni low mid-ON of digit2 -> anodes 1111 and segments 7F in the same cycle, with no clock needed. After release, the first cycle has frame_o = 1 and digit0's slot begins.
